alu_arbiter: RTL

//  Shares the single ALU between two requesters: req0 = execute stage, req1 = branch/address unit.

---
 rtl/alu_arbiter.sv | 108 ++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one ALU between two requesters with a watchdog on stuck ops.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (req0 wins); default is round-robin.
module alu_arbiter #(
  parameter int DATA_W         = 32,
  parameter int OP_W           = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk_w_i,
  input  logic              rst_w_i,
  input  logic              req0_valid_i,
  output logic              req0_ready_o,
  input  logic [OP_W-1:0]   req0_op_i,
  input  logic [DATA_W-1:0] req0_a_i,
  input  logic [DATA_W-1:0] req0_b_i,
  input  logic              req1_valid_i,
  output logic              req1_ready_o,
  input  logic [OP_W-1:0]   req1_op_i,
  input  logic [DATA_W-1:0] req1_a_i,
  input  logic [DATA_W-1:0] req1_b_i,
  output logic [1:0]        rsp_valid_o,
  output logic [DATA_W-1:0] rsp_data_o,
  output logic              rsp_err_o,
  output logic              alu_start_o,
  output logic [OP_W-1:0]   alu_op_o,
  output logic [DATA_W-1:0] alu_a_o,
  output logic [DATA_W-1:0] alu_b_o,
  input  logic              alu_done_i,
  input  logic [DATA_W-1:0] alu_result_i
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;
  state_e            state_q;
  logic              id_q;
  logic [CW-1:0]     cnt_q;
  logic [1:0]        rsp_valid_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic              rsp_err_q;
  logic              start_q;
  logic [OP_W-1:0]   op_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic              gnt1;
  logic              acc;
`ifdef ALU_ARB_FIXED_PRIO_EN
  always_comb gnt1 = req1_valid_i && !req0_valid_i;
`else
  logic last_q;
  // On a tie the requester that did not win last time gets the ALU.
  always_comb gnt1 = req1_valid_i && (!req0_valid_i || !last_q);
  always_ff @(posedge clk_w_i)
    if (rst_w_i) last_q <= 1'b1;
    else if (acc) last_q <= gnt1;
`endif
  always_comb begin
    acc          = (state_q == IDLE) && !rst_w_i && (req0_valid_i || req1_valid_i);
    req0_ready_o = acc && !gnt1;
    req1_ready_o = acc && gnt1;
  end
  always_ff @(posedge clk_w_i) begin
    if (rst_w_i) begin
      state_q     <= IDLE;
      id_q        <= 1'b0;
      cnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      start_q     <= 1'b0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
    end else begin
      start_q     <= 1'b0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      case (state_q)
        IDLE: if (acc) begin
          state_q <= ISSUE;
          start_q <= 1'b1;
          id_q    <= gnt1;
          op_q    <= gnt1 ? req1_op_i : req0_op_i;
          a_q     <= gnt1 ? req1_a_i : req0_a_i;
          b_q     <= gnt1 ? req1_b_i : req0_b_i;
        end
        ISSUE, WAIT: begin
          // Done beats the watchdog when both land in the same cycle.
          if (alu_done_i || (state_q == WAIT && cnt_q == CW'(TIMEOUT_CYCLES))) begin
            state_q     <= RESP;
            rsp_valid_q <= id_q ? 2'b10 : 2'b01;
            rsp_data_q  <= alu_done_i ? alu_result_i : '0;
            rsp_err_q   <= !alu_done_i;
          end else begin
            state_q <= WAIT;
            cnt_q   <= (state_q == ISSUE) ? CW'(1) : cnt_q + CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_err_o   = rsp_err_q;
  assign alu_start_o = start_q;
  assign alu_op_o    = op_q;
  assign alu_a_o     = a_q;
  assign alu_b_o     = b_q;
endmodule
